iter_adder: RTL and testbench

//  Parametrised multi-cycle add/subtract unit. It is the successor to the fixed 4-bit ripple adder.
//  A WIDTH-bit operation is processed CHUNK bits per cycle, LSB chunk first, through one shared ripple chunk.

---
 rtl/adder_pkg.sv | 16 +
 rtl/chunk_adder.sv | 31 +++
 rtl/iter_adder.sv | 122 ++++++++++++
 tb/tb_iter_adder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the iterative add/subtract unit.
// The package declares no ports. It provides:
//   state_t        controller state encoding
//   OP_ADD/OP_SUB  encodings of the sub input
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunk_adder.sv
// Combinational ripple adder for one chunk of W bits.
// Ports:
//   a, b  [W]  chunk operands
//   ci         carry into bit 0
//   s     [W]  chunk sum
//   co         carry out of bit W-1
//   cmsb       carry into bit W-1 (XOR with co gives signed overflow)
module chunk_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         cmsb
);

  logic [W:0] cy;

  assign cy[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]    = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
  end

  assign co   = cy[W];
  assign cmsb = cy[W-1];

endmodule

// File: rtl/iter_adder.sv
// Multi-cycle add/subtract unit. It processes a WIDTH-bit operation CHUNK bits
// per cycle, starting with the LSB chunk, through one shared ripple chunk.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   operand handshake (a, b, ci, sub)
//   out_valid / out_ready result handshake (y, c, v, z, n)
//   y                     result; c carry (sub: 1 = no borrow)
//   v                     signed overflow; z y==0; n y MSB
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding one chunk per cycle, inputs ignored
// DONE  | result held, out_valid=1 until out_ready
module iter_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic             v,
  output logic             z,
  output logic             n
);

  if ((WIDTH < 2) || (CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_param_err
    $error("iter_adder: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [KW-1:0]    k;
  logic [CHUNK-1:0] sum;
  logic             co;
  logic             cmsb;

  // Operands are shifted right each cycle so the adder always sees the
  // chunk under work in the low bits; only y needs the index.
  chunk_adder #(.W(CHUNK)) u_chunk (
    .a    (a_sh[CHUNK-1:0]),
    .b    (b_sh[CHUNK-1:0]),
    .ci   (carry),
    .s    (sum),
    .co   (co),
    .cmsb (cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      k         <= '0;
      y         <= '0;
      c         <= 1'b0;
      v         <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= (sub == OP_ADD) ? b : ~b;
            carry    <= (sub == OP_SUB) ? ~ci : ci;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          y[k*CHUNK +: CHUNK] <= sum;
          carry <= co;
          a_sh  <= a_sh >> CHUNK;
          b_sh  <= b_sh >> CHUNK;
          k     <= k + 1'b1;
          if (k == K_LAST) begin
            c         <= co;
            v         <= cmsb ^ co;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Gating with out_valid keeps z/n at zero out of reset and outside DONE.
  assign z = out_valid & (y == '0);
  assign n = out_valid & y[WIDTH-1];

endmodule

// File: tb/tb_iter_adder.sv
// Self-checking bench for iter_adder. It instantiates a 16/4 unit and an
// 8/8 single-cycle unit.
module tb_iter_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        in_valid16 = 1'b0, out_ready16 = 1'b0, ci16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        in_ready16, out_valid16, c16, v16, z16, n16;
  logic [15:0] y16;

  logic        in_valid8 = 1'b0, out_ready8 = 1'b0, ci8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8, c8, v8, z8, n8;
  logic [7:0]  y8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iter_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .ci(ci16), .sub(sub16), .out_valid(out_valid16),
    .out_ready(out_ready16), .y(y16), .c(c16), .v(v16), .z(z16), .n(n16)
  );

  iter_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .ci(ci8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(out_ready8), .y(y8), .c(c8), .v(v8), .z(z8), .n(n8)
  );

  // Present one op, wait for the accept edge, then count edges until out_valid.
  task automatic op16(input logic [15:0] ia, input logic [15:0] ib,
                      input logic ici, input logic isub, output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready16 && g < 50) begin @(negedge clk); g++; end
    a16 = ia; b16 = ib; ci16 = ici; sub16 = isub; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic release16();
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
  endtask

  task automatic op8(input logic [7:0] ia, input logic [7:0] ib,
                     input logic ici, input logic isub, output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready8 && g < 50) begin @(negedge clk); g++; end
    a8 = ia; b8 = ib; ci8 = ici; sub8 = isub; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic release8();
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({y16, c16, v16, z16, n16, out_valid16} !== 22'h0) begin
      failures++;
      $display("FAIL reset16_outputs got y=%h c=%b v=%b z=%b n=%b ov=%b exp all zero",
               y16, c16, v16, z16, n16, out_valid16);
    end
    checks++;
    if (in_ready16 !== 1'b1) begin
      failures++; $display("FAIL reset16_in_ready got=%b exp=1", in_ready16);
    end
    checks++;
    if ({y8, c8, v8, z8, n8, out_valid8, in_ready8} !== 15'h0001) begin
      failures++;
      $display("FAIL reset8_outputs got y=%h c=%b v=%b z=%b n=%b ov=%b ir=%b exp zero/ir=1",
               y8, c8, v8, z8, n8, out_valid8, in_ready8);
    end
  endtask

  task automatic test_add_overflow();
    int lat;
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL add_ovf_latency got=%0d exp=4", lat); end
    checks++;
    if ({y16, c16, v16, z16, n16} !== {16'h8000, 4'b0101}) begin
      failures++;
      $display("FAIL add_ovf_result got y=%h cvzn=%b%b%b%b exp y=8000 cvzn=0101",
               y16, c16, v16, z16, n16);
    end
    checks++;
    if (in_ready16 !== 1'b0) begin failures++; $display("FAIL add_ovf_in_ready got=%b exp=0", in_ready16); end
    release16();
  endtask

  task automatic test_add_carry();
    int lat;
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    checks++;
    if ({y16, c16, v16, z16, n16} !== {16'h0000, 4'b1010}) begin
      failures++;
      $display("FAIL add_carry_result got y=%h cvzn=%b%b%b%b exp y=0000 cvzn=1010",
               y16, c16, v16, z16, n16);
    end
    release16();
  endtask

  task automatic test_sub();
    int lat;
    op16(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
    checks++;
    if ({y16, c16, v16, z16, n16} !== {16'hFFFE, 4'b0001}) begin
      failures++;
      $display("FAIL sub_neg_result got y=%h cvzn=%b%b%b%b exp y=fffe cvzn=0001",
               y16, c16, v16, z16, n16);
    end
    release16();
    op16(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
    checks++;
    if ({y16, c16, v16, z16, n16} !== {16'h7FFF, 4'b1100}) begin
      failures++;
      $display("FAIL sub_ovf_result got y=%h cvzn=%b%b%b%b exp y=7fff cvzn=1100",
               y16, c16, v16, z16, n16);
    end
    release16();
    op16(16'h1000, 16'h0001, 1'b1, 1'b1, lat);
    checks++;
    if ({y16, c16} !== {16'h0FFE, 1'b1}) begin
      failures++; $display("FAIL sub_borrow_in got y=%h c=%b exp y=0ffe c=1", y16, c16);
    end
    release16();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    op16(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid16 = i[0]; a16 = 16'hAAAA; b16 = 16'h5555;
      @(posedge clk); #1;
      if ({y16, c16, v16, z16, n16, out_valid16, in_ready16} !== {16'h3333, 4'b0000, 2'b10}) bad++;
    end
    in_valid16 = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL backpressure_hold got %0d unstable cycles exp 0", bad);
    end
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
    checks++;
    if ({in_ready16, out_valid16} !== 2'b10) begin
      failures++;
      $display("FAIL backpressure_release got ir=%b ov=%b exp ir=1 ov=0", in_ready16, out_valid16);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'hFFFF; ci16 = 1'b1; sub16 = 1'b0; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({y16, c16, v16, z16, n16, out_valid16, in_ready16} !== {16'h0, 4'b0, 2'b01}) begin
      failures++;
      $display("FAIL midrun_reset got y=%h ov=%b ir=%b exp y=0000 ov=0 ir=1",
               y16, out_valid16, in_ready16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (out_valid16 !== 1'b0) begin
      failures++; $display("FAIL midrun_no_reissue got ov=%b exp=0", out_valid16);
    end
    op16(16'h1234, 16'h4321, 1'b1, 1'b0, lat);
    checks++;
    if ({y16, c16} !== {16'h5556, 1'b0}) begin
      failures++; $display("FAIL after_reset_op got y=%h c=%b exp y=5556 c=0", y16, c16);
    end
    release16();
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    int ydone;
    first = -1; second = -1; ydone = 0;
    @(negedge clk);
    out_ready16 = 1'b1;
    a16 = 16'h0003; b16 = 16'h0004; ci16 = 1'b0; sub16 = 1'b0; in_valid16 = 1'b1;
    for (int cyc = 0; cyc < 40 && second < 0; cyc++) begin
      if (in_valid16 && in_ready16) begin
        if (first < 0) first = cyc; else second = cyc;
      end
      if (out_valid16 && y16 == 16'h0007) ydone = 1;
      @(negedge clk);
    end
    in_valid16 = 1'b0;
    checks++;
    if (second - first != 6) begin
      failures++;
      $display("FAIL back_to_back_interval got=%0d exp=6 (first=%0d second=%0d)",
               second - first, first, second);
    end
    checks++;
    if (ydone != 1) begin failures++; $display("FAIL back_to_back_result got seen=%0d exp=1", ydone); end
    repeat (8) @(negedge clk);
    out_ready16 = 1'b0;
  endtask

  task automatic test_chunk8();
    int lat;
    op8(8'h80, 8'h80, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL chunk8_latency got=%0d exp=1", lat); end
    checks++;
    if ({y8, c8, v8, z8, n8} !== {8'h00, 4'b1110}) begin
      failures++;
      $display("FAIL chunk8_result got y=%h cvzn=%b%b%b%b exp y=00 cvzn=1110", y8, c8, v8, z8, n8);
    end
    release8();
  endtask

  task automatic test_random8();
    int lat;
    int shown;
    logic [7:0] ra, rb, beff, ey;
    logic       rci, rsub, cin, ec, ev;
    logic [8:0] full;
    shown = 0;
    for (int i = 0; i < 10000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rci = 1'($urandom); rsub = 1'($urandom);
      beff = rsub ? ~rb : rb;
      cin  = rsub ? ~rci : rci;
      full = {1'b0, ra} + {1'b0, beff} + {8'h00, cin};
      ey = full[7:0];
      ec = full[8];
      ev = (ra[7] == beff[7]) && (ey[7] != ra[7]);
      op8(ra, rb, rci, rsub, lat);
      checks++;
      if ({y8, c8, v8, z8, n8} !== {ey, ec, ev, (ey == 8'h00), ey[7]} || lat != 1) begin
        failures++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random8 a=%h b=%h ci=%b sub=%b got y=%h cvzn=%b%b%b%b lat=%0d exp y=%h cvzn=%b%b%b%b lat=1",
                   ra, rb, rci, rsub, y8, c8, v8, z8, n8, lat, ey, ec, ev, (ey == 8'h00), ey[7]);
        end
      end
      release8();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_overflow();
    test_add_carry();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_chunk8();
    test_random8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
